// File: rtl/riscv_pkg.sv
// Shared constants for the integer pipeline: widths, register count, writeback source codes.
// No logic; no latency.
// No flow control.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CNTW = 64;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // Encodings carried on wb_alu_sel.
  localparam logic WB_SRC_ALU = 1'b1;
  localparam logic WB_SRC_MEM = 1'b0;

endpackage

// File: rtl/regfile_bank.sv
// Architectural register array: one synchronous write port, two asynchronous read ports.
// Write lands on the next rising edge; reads are combinational.
// No flow control; asynchronous clear wipes every entry.
module regfile_bank
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  // Write port with async clear; entry 0 is never written, so it stays zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register file, counts retirements.
// wb_value and read data are combinational (same-cycle bypass); writes and instret update on the next edge.
// No backpressure: every valid MEM/WB slot retires in the cycle it is presented.
module wb_regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            wb_valid,
  input  logic            wb_alu_sel,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_mem_data,
  input  logic [XLEN-1:0] wb_alu,
  input  logic [AW-1:0]   wb_rd,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_value,
  output logic            wb_commit,
  output logic [CNTW-1:0] instret
);

  logic [XLEN-1:0] bank_rd1;
  logic [XLEN-1:0] bank_rd2;
  logic [CNTW-1:0] instret_q;

  // Writeback source mux stays live during clear so forwarding sees a stable value.
  assign wb_value  = (wb_alu_sel == WB_SRC_ALU) ? wb_alu : wb_mem_data;

  // Bubbles never write, even when wb_we is left over from a squashed instruction.
  assign wb_commit = !clr && wb_valid && wb_we && (wb_rd != REG_ZERO);

  regfile_bank u_bank (
    .clk    (clk),
    .clr    (clr),
    .we     (wb_commit),
    .waddr  (wb_rd),
    .wdata  (wb_value),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (bank_rd1),
    .rdata2 (bank_rd2)
  );

  // Read port 1: clear and x0 force zero, otherwise bypass the in-flight write.
  always_comb begin
    rs1_data = bank_rd1;
    if (clr || (rs1_addr == REG_ZERO)) begin
      rs1_data = '0;
    end else if (wb_commit && (rs1_addr == wb_rd)) begin
      rs1_data = wb_value;
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    rs2_data = bank_rd2;
    if (clr || (rs2_addr == REG_ZERO)) begin
      rs2_data = '0;
    end else if (wb_commit && (rs2_addr == wb_rd)) begin
      rs2_data = wb_value;
    end
  end

  // Retired-instruction counter: every valid slot retires, written or not; wraps silently.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      instret_q <= '0;
    end else if (wb_valid) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
// Inputs change on the falling edge; outputs are sampled between edges.
// Expected values are hand-computed constants.
module tb_wb_regfile;
  import riscv_pkg::*;

  logic            clk;
  logic            clr;
  logic            wb_valid;
  logic            wb_alu_sel;
  logic            wb_we;
  logic [XLEN-1:0] wb_mem_data;
  logic [XLEN-1:0] wb_alu;
  logic [AW-1:0]   wb_rd;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] wb_value;
  logic            wb_commit;
  logic [CNTW-1:0] instret;

  int checks   = 0;
  int failures = 0;

  wb_regfile dut (
    .clk         (clk),
    .clr         (clr),
    .wb_valid    (wb_valid),
    .wb_alu_sel  (wb_alu_sel),
    .wb_we       (wb_we),
    .wb_mem_data (wb_mem_data),
    .wb_alu      (wb_alu),
    .wb_rd       (wb_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_value    (wb_value),
    .wb_commit   (wb_commit),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; wb_valid = 1'b0; wb_alu_sel = 1'b1; wb_we = 1'b0;
    wb_mem_data = '0; wb_alu = '0; wb_rd = '0; rs1_addr = '0; rs2_addr = '0;

    // Reset state.
    #2;
    chk("rst_instret", instret, 64'd0);
    chk("rst_commit", {63'd0, wb_commit}, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    // Preload x5 = 0x1234.
    @(negedge clk);
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd5; wb_alu = 32'h1234; wb_alu_sel = 1'b1;
    @(negedge clk);
    wb_valid = 1'b0; rs1_addr = 5'd5;
    #1;
    chk("preload_x5", rs1_data, 64'h1234);
    chk("preload_instret", instret, 64'd1);

    // Mid-cycle clear with a pending write to x6.
    #1;
    clr = 1'b1; wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd6; wb_alu = 32'h77; rs2_addr = 5'd6;
    #1;
    chk("clr_rs1_immediate", rs1_data, 64'd0);
    chk("clr_instret_immediate", instret, 64'd0);
    chk("clr_commit", {63'd0, wb_commit}, 64'd0);
    chk("clr_wb_value_mux", wb_value, 64'h77);
    @(posedge clk);
    #1;
    chk("clr_edge_instret", instret, 64'd0);
    @(negedge clk);
    clr = 1'b0; wb_valid = 1'b0;
    #1;
    chk("clr_x5_cleared", rs1_data, 64'd0);
    chk("clr_x6_not_written", rs2_data, 64'd0);

    // Writeback select: ALU then memory into x3.
    @(negedge clk);
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd3;
    wb_alu = 32'hAAAA_0001; wb_mem_data = 32'h5555_0002; wb_alu_sel = 1'b1;
    @(negedge clk);
    wb_valid = 1'b0; rs1_addr = 5'd3;
    #1;
    chk("sel_alu_x3", rs1_data, 64'hAAAA_0001);
    wb_valid = 1'b1; wb_alu_sel = 1'b0;
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("sel_mem_x3", rs1_data, 64'h5555_0002);
    chk("sel_instret", instret, 64'd2);

    // Bypass: both ports read x7 while it is being written.
    @(negedge clk);
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd7; wb_alu = 32'hDEAD_BEEF; wb_alu_sel = 1'b1;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    chk("byp_rs1", rs1_data, 64'hDEAD_BEEF);
    chk("byp_rs2", rs2_data, 64'hDEAD_BEEF);
    chk("byp_commit", {63'd0, wb_commit}, 64'd1);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("byp_stored_x7", rs1_data, 64'hDEAD_BEEF);

    // x0: write discarded, reads zero even on bypass match.
    @(negedge clk);
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd0; wb_alu = 32'hFFFF_FFFF; rs1_addr = 5'd0;
    #1;
    chk("x0_rs1_during", rs1_data, 64'd0);
    chk("x0_commit_during", {63'd0, wb_commit}, 64'd0);
    @(posedge clk);
    #1;
    chk("x0_rs1_after", rs1_data, 64'd0);
    chk("x0_commit_after", {63'd0, wb_commit}, 64'd0);

    // Bubble with stale write enable.
    @(negedge clk);
    wb_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd9; wb_alu = 32'h1; rs1_addr = 5'd9;
    #1;
    chk("bub_commit", {63'd0, wb_commit}, 64'd0);
    chk("bub_instret_before", instret, 64'd4);
    @(posedge clk);
    #1;
    chk("bub_x9", rs1_data, 64'd0);
    chk("bub_instret_after", instret, 64'd4);

    // Ten valid stores: counter advances, registers untouched.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wb_valid = 1'b1; wb_we = 1'b0; wb_rd = 5'd3; wb_alu = 32'h100 + i;
    end
    @(negedge clk);
    wb_valid = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd7;
    #1;
    chk("cnt_instret_plus10", instret, 64'd14);
    chk("cnt_x3_kept", rs1_data, 64'h5555_0002);
    chk("cnt_x7_kept", rs2_data, 64'hDEAD_BEEF);

    // Counter wrap from all-ones.
    @(negedge clk);
    dut.instret_q = {CNTW{1'b1}};
    #1;
    chk("wrap_preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    wb_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap_to_zero", instret, 64'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_hold", instret, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
